// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, queue push,
// redirect (flush) and BTB update. master = fetch unit, slave = environment.
interface instruction_fetch_unit_if #(
    parameter int DATAWITHBIT = 32
);
    // redirect
    logic                   i_flush;
    logic [31:0]            i_redirect_pc;
    // instruction memory
    logic                   o_imem_req;
    logic [31:0]            o_imem_addr;
    logic                   i_imem_gnt;
    logic                   i_imem_rvalid;
    logic [DATAWITHBIT-1:0] i_imem_rdata;
    // instruction queue push
    logic                   o_wrt_en;
    logic [DATAWITHBIT-1:0] o_wrt_data;
    logic [31:0]            o_wrt_inst_pc;
    logic                   o_wrt_taken;
    logic [31:0]            o_wrt_target;
    logic                   i_full;
    // BTB update from branch resolution
    logic                   i_upd_en;
    logic [31:0]            i_upd_pc;
    logic                   i_upd_taken;
    logic [31:0]            i_upd_target;

    modport master (
        input  i_flush, i_redirect_pc,
        output o_imem_req, o_imem_addr,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        output o_wrt_en, o_wrt_data, o_wrt_inst_pc,
        output o_wrt_taken, o_wrt_target,
        input  i_full,
        input  i_upd_en, i_upd_pc, i_upd_taken, i_upd_target
    );

    modport slave (
        output i_flush, i_redirect_pc,
        input  o_imem_req, o_imem_addr,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        input  o_wrt_en, o_wrt_data, o_wrt_inst_pc,
        input  o_wrt_taken, o_wrt_target,
        output i_full,
        output i_upd_en, i_upd_pc, i_upd_taken, i_upd_target
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, pushes (inst, pc,
// prediction) into the instruction queue, direct-mapped BTB with 2-bit
// counters, flush/redirect with draining of a stale response.
// Ports: clk, rstn (async, active-low), bus (instruction_fetch_unit_if.master).
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16,
    parameter int          DATAWITHBIT = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    instruction_fetch_unit_if.master   bus
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_PUSH,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [1:0]       ctr;
        logic [29:0]      target;
    } btb_entry_t;

    state_t state_q;
    state_t state_d;

    logic [31:0]            pc_q;
    logic [31:0]            next_pc_q;
    logic [31:0]            inst_pc_q;
    logic                   taken_q;
    logic [31:0]            target_q;
    logic [DATAWITHBIT-1:0] data_q;

    logic imem_req;
    logic wrt_en;
    logic flush;
    logic gnt;
    logic rvalid;

    assign flush  = bus.i_flush;
    assign gnt    = bus.i_imem_gnt;
    assign rvalid = bus.i_imem_rvalid;

    // ---------------- BTB ----------------
    btb_entry_t btb_q [BTB_ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    btb_entry_t       rd_ent;
    logic             pred_taken;
    logic [31:0]      pred_target;

    assign rd_idx      = pc_q[2 +: IDX_W];
    assign rd_ent      = btb_q[rd_idx];
    assign pred_taken  = rd_ent.valid
                       && (rd_ent.tag == pc_q[31 -: TAG_W])
                       && rd_ent.ctr[1];
    assign pred_target = pred_taken ? {rd_ent.target, 2'b00} : 32'h0;

    logic [IDX_W-1:0] wr_idx;
    btb_entry_t       wr_old;
    btb_entry_t       wr_new;
    logic             wr_hit;
    logic             wr_we;

    assign wr_idx = bus.i_upd_pc[2 +: IDX_W];
    assign wr_old = btb_q[wr_idx];
    assign wr_hit = wr_old.valid
                  && (wr_old.tag == bus.i_upd_pc[31 -: TAG_W]);

    always_comb begin
        wr_new = wr_old;
        wr_we  = 1'b0;
        if (bus.i_upd_en) begin
            if (wr_hit) begin
                wr_we = 1'b1;
                if (bus.i_upd_taken) begin
                    if (wr_old.ctr != 2'b11) begin
                        wr_new.ctr = wr_old.ctr + 2'b01;
                    end
                    wr_new.target = bus.i_upd_target[31:2];
                end else if (wr_old.ctr != 2'b00) begin
                    wr_new.ctr = wr_old.ctr - 2'b01;
                end
            end else if (bus.i_upd_taken) begin
                // miss + taken: allocate over whatever lived here
                wr_we         = 1'b1;
                wr_new.valid  = 1'b1;
                wr_new.tag    = bus.i_upd_pc[31 -: TAG_W];
                wr_new.ctr    = 2'b10;
                wr_new.target = bus.i_upd_target[31:2];
            end
        end
    end

    // Written at the clock edge, so a same-cycle lookup sees the old entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_q[i] <= '{valid: 1'b0, tag: '0,
                              ctr: 2'b01, target: '0};
            end
        end else if (wr_we) begin
            btb_q[wr_idx] <= wr_new;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (flush) begin
                    // a granted request is still in flight: drain it
                    state_d = gnt ? S_DRAIN : S_REQ;
                end else if (gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = rvalid ? S_REQ : S_DRAIN;
                end else if (rvalid) begin
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                if (flush || !bus.i_full) begin
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                // stale response absorbed; a flush alone only moves pc
                if (rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        wrt_en   = 1'b0;
        unique case (state_q)
            S_REQ:   imem_req = 1'b1;
            S_PUSH:  wrt_en   = ~bus.i_full & ~flush;
            default: begin
                imem_req = 1'b0;
                wrt_en   = 1'b0;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q      <= RESET_PC;
            next_pc_q <= RESET_PC;
            inst_pc_q <= 32'h0;
            taken_q   <= 1'b0;
            target_q  <= 32'h0;
            data_q    <= '0;
        end else begin
            if (flush) begin
                pc_q <= {bus.i_redirect_pc[31:2], 2'b00};
            end else if (wrt_en) begin
                pc_q <= next_pc_q;
            end
            if (state_q == S_REQ && gnt && !flush) begin
                inst_pc_q <= pc_q;
                taken_q   <= pred_taken;
                target_q  <= pred_target;
                next_pc_q <= pred_taken ? pred_target : pc_q + 32'd4;
            end
            if (state_q == S_WAIT && rvalid && !flush) begin
                data_q <= bus.i_imem_rdata;
            end
        end
    end

    assign bus.o_imem_req    = imem_req;
    assign bus.o_imem_addr   = pc_q;
    assign bus.o_wrt_en      = wrt_en;
    assign bus.o_wrt_data    = data_q;
    assign bus.o_wrt_inst_pc = inst_pc_q;
    assign bus.o_wrt_taken   = taken_q;
    assign bus.o_wrt_target  = target_q;

    // byte-offset bits are ignored throughout
    logic unused_low_bits;
    assign unused_low_bits = ^{bus.i_redirect_pc[1:0],
                               bus.i_upd_pc[1:0],
                               bus.i_upd_target[1:0]};
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run against a fetch-stream / BTB reference model.
module tb_instruction_fetch_unit;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // memory model
    logic        mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    logic        mem_dead;
    int          gnt_pct;
    int          lat_min;
    int          lat_max;

    // BTB update to apply in the next cycle
    logic        u_en;
    logic [31:0] u_pc;
    logic        u_taken;
    logic [31:0] u_tgt;

    // reference model: fetch pc, pending fetched instruction, BTB contents
    logic        m_valid [16];
    logic [25:0] m_tag   [16];
    int          m_ctr   [16];
    logic [31:0] m_tgt   [16];
    logic [31:0] m_pc;
    logic        m_pend_v;
    logic [31:0] m_e_pc, m_e_data, m_e_tgt, m_e_next;
    logic        m_e_tk;

    // per-cycle observations and matching model expectations
    logic        ev_req, ev_gnt, ev_push, ev_has;
    logic [31:0] ev_addr, ev_exp_addr;
    logic [31:0] ev_wdata, ev_wpc, ev_wtgt;
    logic        ev_wtk;
    logic [31:0] ex_pc, ex_data, ex_tgt;
    logic        ex_tk;

    task automatic cycle(input logic full, input logic flush,
                         input logic [31:0] rpc);
        logic        gnt;
        logic        tk;
        logic        hit;
        logic [31:0] tg;
        int          ix;
        @(negedge clk);
        cyc++;
        bus.i_full        = full;
        bus.i_flush       = flush;
        bus.i_redirect_pc = rpc;
        bus.i_upd_en      = u_en;
        bus.i_upd_pc      = u_pc;
        bus.i_upd_taken   = u_taken;
        bus.i_upd_target  = u_tgt;
        bus.i_imem_rvalid = 1'b0;
        bus.i_imem_rdata  = 32'h0;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                bus.i_imem_rvalid = 1'b1;
                bus.i_imem_rdata  = mem_dead ? 32'hDEAD : mem_addr + 32'h100;
                mem_pend = 1'b0;
                mem_dead = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        gnt = 1'b0;
        if (bus.o_imem_req && !mem_pend && !bus.i_imem_rvalid
            && ($urandom_range(99) < gnt_pct)) begin
            gnt = 1'b1;
        end
        bus.i_imem_gnt = gnt;
        if (gnt) begin
            mem_pend = 1'b1;
            mem_addr = bus.o_imem_addr;
            mem_cnt  = int'($urandom_range(lat_max - 1, lat_min - 1));
        end
        #1;
        ev_req      = bus.o_imem_req;
        ev_gnt      = gnt;
        ev_addr     = bus.o_imem_addr;
        ev_exp_addr = m_pc;
        ev_push     = bus.o_wrt_en;
        ev_wdata    = bus.o_wrt_data;
        ev_wpc      = bus.o_wrt_inst_pc;
        ev_wtk      = bus.o_wrt_taken;
        ev_wtgt     = bus.o_wrt_target;
        ev_has      = m_pend_v;
        ex_pc       = m_e_pc;
        ex_data     = m_e_data;
        ex_tk       = m_e_tk;
        ex_tgt      = m_e_tgt;
        // advance the model
        if (flush) begin
            m_pc     = {rpc[31:2], 2'b00};
            m_pend_v = 1'b0;
        end else if (ev_push) begin
            m_pc     = m_e_next;
            m_pend_v = 1'b0;
        end
        if (gnt && !flush) begin
            ix = int'(m_pc[5:2]);
            tk = m_valid[ix] && (m_tag[ix] == m_pc[31:6]) && (m_ctr[ix] >= 2);
            tg = tk ? m_tgt[ix] : 32'h0;
            m_e_pc   = m_pc;
            m_e_data = m_pc + 32'h100;
            m_e_tk   = tk;
            m_e_tgt  = tg;
            m_e_next = tk ? tg : m_pc + 32'd4;
            m_pend_v = 1'b1;
        end
        if (u_en) begin
            ix  = int'(u_pc[5:2]);
            hit = m_valid[ix] && (m_tag[ix] == u_pc[31:6]);
            if (hit) begin
                if (u_taken) begin
                    if (m_ctr[ix] < 3) m_ctr[ix]++;
                    m_tgt[ix] = {u_tgt[31:2], 2'b00};
                end else if (m_ctr[ix] > 0) begin
                    m_ctr[ix]--;
                end
            end else if (u_taken) begin
                m_valid[ix] = 1'b1;
                m_tag[ix]   = u_pc[31:6];
                m_ctr[ix]   = 2;
                m_tgt[ix]   = {u_tgt[31:2], 2'b00};
            end
        end
        u_en = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.i_flush = 0; bus.i_redirect_pc = 0;
        bus.i_imem_gnt = 0; bus.i_imem_rvalid = 0; bus.i_imem_rdata = 0;
        bus.i_full = 0; bus.i_upd_en = 0; bus.i_upd_pc = 0;
        bus.i_upd_taken = 0; bus.i_upd_target = 0;
        mem_pend = 0; mem_cnt = 0; mem_addr = 0; mem_dead = 0;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        u_en = 0; u_pc = 0; u_taken = 0; u_tgt = 0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = 0;
        end
        m_pc = 32'h0; m_pend_v = 0;
        m_e_pc = 0; m_e_data = 0; m_e_tgt = 0; m_e_next = 0; m_e_tk = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.o_imem_req !== 1'b0 || bus.o_imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_imem: req=%b addr=%h want 0/0",
                     bus.o_imem_req, bus.o_imem_addr);
        end
        checks++;
        if ({bus.o_wrt_en, bus.o_wrt_data, bus.o_wrt_inst_pc,
             bus.o_wrt_taken, bus.o_wrt_target} !== '0) begin
            errors++;
            $display("FAIL reset_queue: en=%b data=%h pc=%h tk=%b tgt=%h want 0",
                     bus.o_wrt_en, bus.o_wrt_data, bus.o_wrt_inst_pc,
                     bus.o_wrt_taken, bus.o_wrt_target);
        end
        rstn = 1'b1;
        cyc  = 0;
        #1;
        checks++;
        if (bus.o_imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_cycle: req=%b want 0", bus.o_imem_req);
        end
        cycle(0, 0, 0);
        checks++;
        if (ev_req !== 1'b1 || ev_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h want 1/00000000",
                     ev_req, ev_addr);
        end
    endtask

    task automatic test_sequential();
        int n = 0;
        int last = 0;
        for (int k = 0; k < 15; k++) begin
            cycle(0, 0, 0);
            if (ev_push) begin
                checks++;
                if (ev_wpc !== 32'(4 * n) || ev_wdata !== 32'(32'h100 + 4 * n)
                    || ev_wtk !== 1'b0 || ev_wtgt !== 32'h0) begin
                    errors++;
                    $display("FAIL seq_push%0d: pc=%h data=%h tk=%b tgt=%h want %h/%h/0/0",
                             n, ev_wpc, ev_wdata, ev_wtk, ev_wtgt,
                             32'(4 * n), 32'(32'h100 + 4 * n));
                end
                checks++;
                if (cyc !== last + 3) begin
                    errors++;
                    $display("FAIL seq_rate%0d: push cycle %0d want %0d",
                             n, cyc, last + 3);
                end
                last = cyc;
                n++;
                if (n == 3) break;
            end
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL seq_timeout: pushes=%0d want 3", n);
        end
    endtask

    task automatic test_full_stall();
        logic ok = 0;
        int   pushes = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1, 0, 0);
            if (ev_gnt) begin ok = 1; break; end
        end
        checks++;
        if (!ok || ev_addr !== 32'hC) begin
            errors++;
            $display("FAIL full_gnt: seen=%b addr=%h want 1/0000000c", ok, ev_addr);
        end
        cycle(1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cycle(1, 0, 0);
            checks++;
            if (ev_push !== 1'b0 || ev_req !== 1'b0 || ev_wpc !== 32'hC
                || ev_wdata !== 32'h10C || ev_wtk !== 1'b0) begin
                errors++;
                $display("FAIL full_hold%0d: en=%b req=%b pc=%h data=%h tk=%b want 0/0/c/10c/0",
                         k, ev_push, ev_req, ev_wpc, ev_wdata, ev_wtk);
            end
        end
        cycle(0, 0, 0);
        checks++;
        if (ev_push !== 1'b1 || ev_wpc !== 32'hC || ev_wdata !== 32'h10C) begin
            errors++;
            $display("FAIL full_release: en=%b pc=%h data=%h want 1/c/10c",
                     ev_push, ev_wpc, ev_wdata);
        end
        for (int k = 0; k < 2; k++) begin
            cycle(0, 0, 0);
            if (ev_push) pushes++;
        end
        checks++;
        if (pushes != 0) begin
            errors++;
            $display("FAIL full_single_push: extra pushes=%0d want 0", pushes);
        end
    endtask

    task automatic test_flush_wait();
        logic ok = 0;
        lat_min = 3; lat_max = 3;
        for (int k = 0; k < 20; k++) begin
            cycle(0, 0, 0);
            if (ev_gnt) begin ok = 1; break; end
        end
        mem_dead = 1'b1;
        lat_min = 1; lat_max = 1;
        cycle(0, 1, 32'h200);
        checks++;
        if (!ok || ev_push !== 1'b0) begin
            errors++;
            $display("FAIL flushw_nopush: gnt_seen=%b en=%b want 1/0", ok, ev_push);
        end
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        checks++;
        if (ev_req !== 1'b0 || ev_push !== 1'b0) begin
            errors++;
            $display("FAIL flushw_drain: req=%b en=%b want 0/0", ev_req, ev_push);
        end
        cycle(0, 0, 0);
        checks++;
        if (ev_req !== 1'b1 || ev_addr !== 32'h200) begin
            errors++;
            $display("FAIL flushw_redirect: req=%b addr=%h want 1/00000200",
                     ev_req, ev_addr);
        end
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(0, 0, 0);
            if (ev_push) begin ok = 1; break; end
        end
        checks++;
        if (!ok || ev_wpc !== 32'h200 || ev_wdata !== 32'h300) begin
            errors++;
            $display("FAIL flushw_push: seen=%b pc=%h data=%h want 1/200/300",
                     ok, ev_wpc, ev_wdata);
        end
    endtask

    task automatic test_flush_push();
        logic ok = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(0, 0, 0);
            if (ev_gnt) begin ok = 1; break; end
        end
        cycle(0, 0, 0);
        cycle(0, 1, 32'h300);
        checks++;
        if (!ok || ev_push !== 1'b0) begin
            errors++;
            $display("FAIL flushp_nopush: gnt_seen=%b en=%b want 1/0", ok, ev_push);
        end
        cycle(0, 0, 0);
        checks++;
        if (ev_req !== 1'b1 || ev_addr !== 32'h300) begin
            errors++;
            $display("FAIL flushp_redirect: req=%b addr=%h want 1/00000300",
                     ev_req, ev_addr);
        end
    endtask

    task automatic expect_push(input string nm, input logic tk,
                               input logic [31:0] tgt, input logic [31:0] nxt);
        logic ok = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(0, 0, 0);
            if (ev_push) begin ok = 1; break; end
        end
        checks++;
        if (!ok || ev_wpc !== 32'h40 || ev_wtk !== tk || ev_wtgt !== tgt) begin
            errors++;
            $display("FAIL %s_push: seen=%b pc=%h tk=%b tgt=%h want 1/40/%b/%h",
                     nm, ok, ev_wpc, ev_wtk, ev_wtgt, tk, tgt);
        end
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(0, 0, 0);
            if (ev_gnt) begin ok = 1; break; end
        end
        checks++;
        if (!ok || ev_addr !== nxt) begin
            errors++;
            $display("FAIL %s_next: seen=%b addr=%h want 1/%h", nm, ok, ev_addr, nxt);
        end
    endtask

    task automatic test_btb_taken();
        u_en = 1; u_pc = 32'h40; u_taken = 1; u_tgt = 32'h80;
        cycle(0, 1, 32'h40);
        expect_push("btb_taken", 1'b1, 32'h80, 32'h80);
    endtask

    task automatic test_hysteresis();
        u_en = 1; u_pc = 32'h40; u_taken = 0; u_tgt = 32'h0;
        cycle(0, 0, 0);
        cycle(0, 1, 32'h40);
        expect_push("hyst_nt", 1'b0, 32'h0, 32'h44);
        for (int k = 0; k < 3; k++) begin
            u_en = 1; u_pc = 32'h40; u_taken = (k < 2); u_tgt = 32'h80;
            cycle(0, 0, 0);
        end
        cycle(0, 1, 32'h40);
        expect_push("hyst_strong", 1'b1, 32'h80, 32'h80);
    endtask

    task automatic test_wrap();
        logic ok;
        logic [31:0] want [3];
        logic [31:0] rpc [3];
        want[0] = 32'hFFFF_FFFC; want[1] = 32'h0;   want[2] = 32'h200;
        rpc[0]  = 32'hFFFF_FFFC; rpc[1]  = 32'h0;   rpc[2]  = 32'h203;
        for (int t = 0; t < 3; t++) begin
            if (t != 1) cycle(0, 1, rpc[t]);
            ok = 0;
            for (int k = 0; k < 20; k++) begin
                cycle(0, 0, 0);
                if (ev_gnt) begin ok = 1; break; end
            end
            checks++;
            if (!ok || ev_addr !== want[t]) begin
                errors++;
                $display("FAIL wrap%0d: seen=%b addr=%h want 1/%h",
                         t, ok, ev_addr, want[t]);
            end
        end
    endtask

    task automatic test_random();
        int pushes = 0;
        logic full, flush;
        logic [31:0] rpc;
        gnt_pct = 60; lat_min = 1; lat_max = 4;
        for (int k = 0; k < 3000; k++) begin
            full  = ($urandom_range(99) < 30);
            flush = ($urandom_range(99) < 4);
            rpc   = 32'h100 + 4 * $urandom_range(31) + $urandom_range(3);
            if ($urandom_range(99) < 20) begin
                u_en    = 1;
                u_pc    = 32'h100 + 4 * $urandom_range(31);
                u_taken = $urandom_range(1);
                u_tgt   = 32'h100 + 4 * $urandom_range(31);
            end
            cycle(full, flush, rpc);
            if (ev_gnt) begin
                checks++;
                if (ev_addr !== ev_exp_addr) begin
                    errors++;
                    $display("FAIL rnd_addr@%0d: addr=%h want %h",
                             cyc, ev_addr, ev_exp_addr);
                end
            end
            if (ev_push) begin
                pushes++;
                checks++;
                if (!ev_has || ev_wpc !== ex_pc || ev_wdata !== ex_data
                    || ev_wtk !== ex_tk || ev_wtgt !== ex_tgt) begin
                    errors++;
                    $display("FAIL rnd_push@%0d: exp=%b pc=%h data=%h tk=%b tgt=%h want %h/%h/%b/%h",
                             cyc, ev_has, ev_wpc, ev_wdata, ev_wtk, ev_wtgt,
                             ex_pc, ex_data, ex_tk, ex_tgt);
                end
            end
        end
        checks++;
        if (pushes < 50) begin
            errors++;
            $display("FAIL rnd_progress: pushes=%0d want >=50", pushes);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_full_stall();
        test_flush_wait();
        test_flush_push();
        test_btb_taken();
        test_hysteresis();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
